piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 127 ++++++++++++
 tb/tb_piso_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with a load/ready handshake and shift stall.
// Words can be chained back to back: a load on the last-bit edge continues without a gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             out_bit;
  logic             sout_next;
  logic             sout_valid_next;
  logic             done_next;
  logic             last_bit;
  logic             leaving;
  logic             accept;

  // Output end of the register and the 0-filled shift toward it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit      = sreg[WIDTH-1];
      assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit      = sreg[0];
      assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit   = (state == SHIFT) && (cnt == CNT_ONE);
  // A counter of zero in SHIFT is unreachable; treat it as finished so the FSM can never stick.
  assign leaving    = (state == SHIFT) && (cnt <= CNT_ONE);
  assign load_ready = (state == IDLE) || ((state == SHIFT) && shift_en && last_bit);
  assign accept     = load_valid && load_ready;
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    sreg_next       = sreg;
    cnt_next        = cnt;
    sout_next       = 1'b0;
    sout_valid_next = 1'b0;
    done_next       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_next  = data;
          cnt_next   = CNT_FULL;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          sout_next       = out_bit;
          sout_valid_next = 1'b1;
          done_next       = last_bit;
          sreg_next       = sreg_shifted;
          if (cnt != CNT_ZERO) begin
            cnt_next = cnt - CNT_ONE;
          end
          if (leaving) begin
            if (accept) begin
              sreg_next  = data;
              cnt_next   = CNT_FULL;
              state_next = SHIFT;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      sreg       <= sreg_next;
      cnt        <= cnt_next;
      sout       <= sout_next;
      sout_valid <= sout_valid_next;
      done       <= done_next;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an MSB-first and an LSB-first serializer with shared stimulus and checks both
// against a small cycle model whose expected bits are queued at each accepted load.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic ready_m, sout_m, valid_m, busy_m, done_m;
  logic ready_l, sout_l, valid_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  bit       q_m[$];
  bit       q_l[$];
  bit       m_busy = 1'b0;
  int       m_cnt = 0;
  logic [15:0] col_m, col_l;
  int       nvalid_m, nvalid_l, ndone_m, ndone_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .data(data), .load_valid(load_valid),
    .load_ready(ready_m), .shift_en(shift_en), .sout(sout_m),
    .sout_valid(valid_m), .busy(busy_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .data(data), .load_valid(load_valid),
    .load_ready(ready_l), .shift_en(shift_en), .sout(sout_l),
    .sout_valid(valid_l), .busy(busy_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    col_m = '0; col_l = '0;
    nvalid_m = 0; nvalid_l = 0; ndone_m = 0; ndone_l = 0;
  endtask

  // One clock: check load_ready, advance the model, then check registered outputs.
  task automatic tick();
    bit er, ev, ed, bm, bl;
    #1;
    er = !m_busy || (shift_en && m_cnt == 1);
    chk("load_ready_msb", ready_m, er);
    chk("load_ready_lsb", ready_l, er);
    ev = 1'b0; ed = 1'b0; bm = 1'b0; bl = 1'b0;
    if (m_busy && shift_en) begin
      ev = 1'b1;
      ed = (m_cnt == 1);
      bm = q_m.pop_front();
      bl = q_l.pop_front();
      m_cnt--;
      if (m_cnt == 0) m_busy = 1'b0;
    end
    if (load_valid && er) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back(data[W-1-i]);
        q_l.push_back(data[i]);
      end
      m_cnt  = W;
      m_busy = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("sout_valid_msb", valid_m, ev);
    chk("sout_valid_lsb", valid_l, ev);
    chk("sout_msb", sout_m, bm);
    chk("sout_lsb", sout_l, bl);
    chk("done_msb", done_m, ed);
    chk("done_lsb", done_l, ed);
    chk("busy_msb", busy_m, m_busy);
    chk("busy_lsb", busy_l, m_busy);
    $display("t=%0t ld=%0b/%0h se=%0b | msb v=%0b s=%0b d=%0b | lsb v=%0b s=%0b d=%0b | busy=%0b",
             $time, load_valid, data, shift_en, valid_m, sout_m, done_m,
             valid_l, sout_l, done_l, busy_m);
    if (valid_m === 1'b1) begin col_m = {col_m[14:0], sout_m}; nvalid_m++; end
    if (valid_l === 1'b1) begin col_l = {sout_l, col_l[15:1]}; nvalid_l++; end
    if (done_m === 1'b1) ndone_m++;
    if (done_l === 1'b1) ndone_l++;
  endtask

  task automatic load_word(input logic [W-1:0] w);
    data = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // Bounded drain with shift_en held high; a DUT still busy afterwards is reported.
  task automatic drain(input string tag);
    shift_en = 1'b1;
    for (int i = 0; i < 40 && m_busy; i++) tick();
    tick();
    chk(tag, busy_m, 1'b0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_sout", {sout_m, sout_l}, 2'b00);
    chk("rst_valid", {valid_m, valid_l}, 2'b00);
    chk("rst_done", {done_m, done_l}, 2'b00);
    chk("rst_busy", {busy_m, busy_l}, 2'b00);
    #8;
    rst_n = 1'b1;
    #2;
    chk("ready_after_rst", {ready_m, ready_l}, 2'b11);
    @(posedge clk); #1;

    // 0xB4 with continuous shifting
    clear_obs();
    shift_en = 1'b1;
    load_word(8'hB4);
    drain("b4_idle");
    chk("b4_word_msb", col_m[7:0], 8'hB4);
    chk("b4_word_lsb", col_l[15:8], 8'hB4);
    chk("b4_nvalid", nvalid_m + nvalid_l, 16);
    chk("b4_ndone", ndone_m + ndone_l, 2);

    // 0xFF with a 3-cycle stall after the 2nd bit
    clear_obs();
    shift_en = 1'b1;
    load_word(8'hFF);
    tick();
    tick();
    shift_en = 1'b0;
    repeat (3) tick();
    chk("stall_busy", {busy_m, busy_l}, 2'b11);
    drain("ff_idle");
    chk("ff_word_msb", col_m[7:0], 8'hFF);
    chk("ff_nvalid", nvalid_m, 8);
    chk("ff_ndone", ndone_l, 1);

    // Back-to-back words with load_valid held high
    clear_obs();
    shift_en = 1'b1;
    data = 8'hB4;
    load_valid = 1'b1;
    tick();
    data = 8'h0F;
    repeat (8) tick();
    load_valid = 1'b0;
    data = 8'h00;
    repeat (7) begin
      tick();
      chk("b2b_busy", busy_m, 1'b1);
    end
    drain("b2b_idle");
    chk("b2b_word_msb", col_m, 16'hB40F);
    chk("b2b_word_lsb", col_l, 16'h0FB4);
    chk("b2b_nvalid", nvalid_m, 16);
    chk("b2b_ndone", ndone_m, 2);

    // Load attempt mid-word must be ignored
    clear_obs();
    shift_en = 1'b1;
    load_word(8'hB4);
    repeat (2) tick();
    data = 8'h00;
    load_valid = 1'b1;
    repeat (3) tick();
    load_valid = 1'b0;
    drain("mid_idle");
    chk("mid_word_msb", col_m[7:0], 8'hB4);
    chk("mid_word_lsb", col_l[15:8], 8'hB4);
    chk("mid_nvalid", nvalid_l, 8);

    // Random words with random stalls
    for (int n = 0; n < 4; n++) begin
      clear_obs();
      shift_en = 1'b1;
      load_word(W'($urandom));
      for (int i = 0; i < 60 && m_busy; i++) begin
        shift_en = ($urandom_range(0, 3) != 0);
        tick();
      end
      drain("rnd_idle");
      chk("rnd_nvalid", nvalid_m, 8);
    end

    // Reset after the 3rd bit abandons the word
    clear_obs();
    shift_en = 1'b1;
    load_word(8'hB4);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_sout", {sout_m, sout_l}, 2'b00);
    chk("arst_valid", {valid_m, valid_l}, 2'b00);
    chk("arst_done", {done_m, done_l}, 2'b00);
    chk("arst_busy", {busy_m, busy_l}, 2'b00);
    q_m.delete();
    q_l.delete();
    m_busy = 1'b0;
    m_cnt = 0;
    #3;
    rst_n = 1'b1;
    #1;
    chk("arst_ready", {ready_m, ready_l}, 2'b11);
    repeat (10) tick();
    chk("arst_nvalid", nvalid_m + nvalid_l, 6);
    chk("arst_partial_msb", col_m[2:0], 3'b101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
